branch_predictor: RTL and testbench

Dynamic branch predictor for the five-stage pipelined MIPS core. It is indexed by the fetch PC and supplies a predicted next PC to the F stage. It receives the branch outcome resolved in D from the core controller and datapath. On a misprediction it raises `restart`, which the controller uses to clear the D→X control registers and the datapath uses to redirect fetch. It combines a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.

---
 rtl/branch_predictor.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_branch_predictor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the five-stage pipelined MIPS core. It is a
// direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per
// entry. The fetch PC is looked up combinationally to produce a predicted next
// PC. The branch outcome resolved in D is compared against the prediction that
// travelled with the instruction. On a mismatch, `restart` redirects fetch and
// flushes F/D and the D->X control registers.
//
// Optional feature macro: BP_STATS_EN
//   When defined, the stat_branches / stat_mispredicts counter ports exist.
//
// Ports
//   clk              core clock
//   reset            asynchronous, active-high reset
//   pc_f             current fetch PC
//   stall_f          F stage held upstream (lookup is stateless, so unused here)
//   stall_d          D stage held: no resolution and no table update
//   predict_taken_f  BTB hit with a counter in a taken state
//   predict_pc_f     predicted next fetch PC
//   branch_d         instruction in D is a conditional branch
//   taken_d          resolved branch outcome
//   branch_target_d  computed branch target in D
//   restart          misprediction detected in D
//   restart_pc       correct next PC for the instruction in D
//   stat_branches    (BP_STATS_EN) resolved branch count, wraps at 2^32
//   stat_mispredicts (BP_STATS_EN) restart count, wraps at 2^32
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        stall_f,
    input  logic        stall_d,
    output logic        predict_taken_f,
    output logic [31:0] predict_pc_f,
    input  logic        branch_d,
    input  logic        taken_d,
    input  logic [31:0] branch_target_d,
    output logic        restart,
    output logic [31:0] restart_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]      tag_t;

    // Two-bit saturating counter step.
    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    // BTB storage
    logic        valid_q  [ENTRIES];
    logic        valid_d  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    tag_t        tag_d    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [31:0] target_d [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];
    logic [1:0]  ctr_d    [ENTRIES];

    // F->D record. rec_valid marks a real instruction; a flushed or reset
    // bubble has rec_valid=0 and can never raise restart.
    logic        rec_valid_q, rec_valid_d;
    logic [31:0] rec_pc_q, rec_pc_d;
    logic        rec_pred_taken_q, rec_pred_taken_d;
    logic [31:0] rec_pred_pc_q, rec_pred_pc_d;

    // Lookup / resolution / write signals
    idx_t        idx_f, idx_dec;
    tag_t        tag_f, tag_dec;
    logic        hit_f, hit_dec;
    logic [31:0] pc_plus4_dec, actual_pc;
    logic        resolve_en;
    logic        wr_en, wr_valid;
    tag_t        wr_tag;
    logic [31:0] wr_target;
    logic [1:0]  wr_ctr;

    // stall_f only holds the upstream PC register; the lookup is purely
    // combinational, so repeating it with the same pc_f gives the same answer.
    logic unused_stall_f;
    assign unused_stall_f = stall_f;

    // Fetch-side lookup and next-PC prediction.
    always_comb begin
        idx_f           = pc_f[INDEX_BITS+1:2];
        tag_f           = pc_f[31:INDEX_BITS+2];
        hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        predict_taken_f = hit_f && ctr_q[idx_f][1];
        if (predict_taken_f) begin
            predict_pc_f = target_q[idx_f];
        end else begin
            predict_pc_f = pc_f + 32'd4;
        end
    end

    // D-stage resolution against the prediction carried in the record.
    always_comb begin
        idx_dec      = rec_pc_q[INDEX_BITS+1:2];
        tag_dec      = rec_pc_q[31:INDEX_BITS+2];
        hit_dec      = valid_q[idx_dec] && (tag_q[idx_dec] == tag_dec);
        pc_plus4_dec = rec_pc_q + 32'd4;
        if (taken_d) begin
            actual_pc = branch_target_d;
        end else begin
            actual_pc = pc_plus4_dec;
        end
        resolve_en = !stall_d && rec_valid_q;
        if (!resolve_en) begin
            restart = 1'b0;
        end else if (branch_d) begin
            restart = (rec_pred_pc_q != actual_pc);
        end else begin
            // Non-branch that was predicted taken: fetch went down a bogus path.
            restart = rec_pred_taken_q;
        end
        if (branch_d) begin
            restart_pc = actual_pc;
        end else begin
            restart_pc = pc_plus4_dec;
        end
    end

    // Next value of the F->D record.
    always_comb begin
        if (restart) begin
            rec_valid_d      = 1'b0;
            rec_pc_d         = 32'd0;
            rec_pred_taken_d = 1'b0;
            rec_pred_pc_d    = 32'd0;
        end else if (!stall_d) begin
            rec_valid_d      = 1'b1;
            rec_pc_d         = pc_f;
            rec_pred_taken_d = predict_taken_f;
            rec_pred_pc_d    = predict_pc_f;
        end else begin
            rec_valid_d      = rec_valid_q;
            rec_pc_d         = rec_pc_q;
            rec_pred_taken_d = rec_pred_taken_q;
            rec_pred_pc_d    = rec_pred_pc_q;
        end
    end

    // Single BTB write per cycle, addressed by the instruction in D.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[idx_dec];
        wr_tag    = tag_q[idx_dec];
        wr_target = target_q[idx_dec];
        wr_ctr    = ctr_q[idx_dec];
        if (!resolve_en) begin
            wr_en = 1'b0;
        end else if (branch_d) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_tag   = tag_dec;
            if (hit_dec) begin
                wr_ctr = sat_ctr(ctr_q[idx_dec], taken_d);
                if (taken_d) begin
                    wr_target = branch_target_d;
                end else begin
                    wr_target = target_q[idx_dec];
                end
            end else begin
                // Allocate with a weak bias toward the observed outcome.
                wr_ctr    = taken_d ? 2'b10 : 2'b01;
                wr_target = branch_target_d;
            end
        end else if (rec_pred_taken_q) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Next-state of every BTB entry.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr_en && (idx_dec == idx_t'(i))) begin
                valid_d[i]  = wr_valid;
                tag_d[i]    = wr_tag;
                target_d[i] = wr_target;
                ctr_d[i]    = wr_ctr;
            end else begin
                valid_d[i]  = valid_q[i];
                tag_d[i]    = tag_q[i];
                target_d[i] = target_q[i];
                ctr_d[i]    = ctr_q[i];
            end
        end
    end

    // BTB registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    // F->D record registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_valid_q      <= 1'b0;
            rec_pc_q         <= 32'd0;
            rec_pred_taken_q <= 1'b0;
            rec_pred_pc_q    <= 32'd0;
        end else begin
            rec_valid_q      <= rec_valid_d;
            rec_pc_q         <= rec_pc_d;
            rec_pred_taken_q <= rec_pred_taken_d;
            rec_pred_pc_q    <= rec_pred_pc_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Statistics counter next-state; both wrap naturally.
    always_comb begin
        if (resolve_en && branch_d) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end else begin
            stat_branches_d = stat_branches_q;
        end
        if (restart) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end else begin
            stat_mispredicts_d = stat_mispredicts_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    // Statistics counters are not built; prediction behaviour is unchanged.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: each step drives one cycle of fetch
// and D-stage inputs, pushes the expected outputs to a scoreboard queue, and
// pops/compares them once the combinational outputs have settled.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        stall_f;
    logic        stall_d;
    logic        predict_taken_f;
    logic [31:0] predict_pc_f;
    logic        branch_d;
    logic        taken_d;
    logic [31:0] branch_target_d;
    logic        restart;
    logic [31:0] restart_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_f            (pc_f),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .predict_taken_f (predict_taken_f),
        .predict_pc_f    (predict_pc_f),
        .branch_d        (branch_d),
        .taken_d         (taken_d),
        .branch_target_d (branch_target_d),
        .restart         (restart),
        .restart_pc      (restart_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Compare all four prediction/resolution outputs right now.
    task automatic check_now(input string name, input logic e_ptf, input logic [31:0] e_ppc,
                             input logic e_rs, input logic [31:0] e_rpc);
        push({name, "_ptf"}, {31'd0, e_ptf});
        push({name, "_ppc"}, e_ppc);
        push({name, "_rs"},  {31'd0, e_rs});
        push({name, "_rpc"}, e_rpc);
        pop_check({31'd0, predict_taken_f});
        pop_check(predict_pc_f);
        pop_check({31'd0, restart});
        pop_check(restart_pc);
    endtask

    // One cycle: drive just after the rising edge, check mid-cycle.
    task automatic step(input string name, input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic sd, input logic e_ptf,
                        input logic [31:0] e_ppc, input logic e_rs, input logic [31:0] e_rpc);
        @(posedge clk);
        #1;
        pc_f            = pc;
        branch_d        = br;
        taken_d         = tk;
        branch_target_d = tgt;
        stall_d         = sd;
        stall_f         = sd;
        #2;
        check_now(name, e_ptf, e_ppc, e_rs, e_rpc);
    endtask

    initial begin
        reset           = 1'b1;
        pc_f            = 32'h40;
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        branch_d        = 1'b0;
        taken_d         = 1'b0;
        branch_target_d = 32'h0;
        #1;
        check_now("in_reset", 1'b0, 32'h44, 1'b0, 32'h4);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check_now("rst_fetch40", 1'b0, 32'h44, 1'b0, 32'h4);
`ifdef BP_STATS_EN
        push("stat_br_rst", 32'd0);  pop_check(stat_branches);
        push("stat_mp_rst", 32'd0);  pop_check(stat_mispredicts);
`endif

        // Cold taken branch at 0x40 -> 0x80, then loop T,T,N,T and decrements.
        //    name    pc_f     br    tk    target  sd    ptf   ppc      rs    rpc
        step("s1",  32'h44, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h48, 1'b1, 32'h80);
        step("s2",  32'h80, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h84, 1'b0, 32'h4);
        step("s3",  32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b0, 32'h84);
        step("s4",  32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h84, 1'b0, 32'h80);
        step("s5",  32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b0, 32'h84);
        step("s6",  32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h84, 1'b0, 32'h80);
        step("s7",  32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b0, 32'h84);
        step("s8",  32'h80, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h84, 1'b1, 32'h44);
        step("s9",  32'h44, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h48, 1'b0, 32'h4);
        step("s10", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b0, 32'h48);
        step("s11", 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h84, 1'b0, 32'h80);
        step("s12", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b0, 32'h84);
        // Counter must be 3 here: one not-taken leaves it predicting taken.
        step("s13", 32'h80, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h84, 1'b1, 32'h44);
        step("s14", 32'h44, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h48, 1'b0, 32'h4);
        step("s15", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80, 1'b0, 32'h48);
        step("s16", 32'h80, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h84, 1'b1, 32'h44);
        step("s17", 32'h44, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h48, 1'b0, 32'h4);
        step("s18", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h44, 1'b0, 32'h48);
        // Drive the counter to 0 and hold it there, then climb back to 1.
        step("s19", 32'h44, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h48, 1'b0, 32'h44);
        step("s20", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h44, 1'b0, 32'h48);
        step("s21", 32'h44, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h48, 1'b0, 32'h44);
        step("s22", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h44, 1'b0, 32'h48);
        step("s23", 32'h44, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h48, 1'b1, 32'h80);
        step("s24", 32'h80, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h84, 1'b0, 32'h4);
        step("s25", 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h44, 1'b0, 32'h84);
        step("s26", 32'h44, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h48, 1'b1, 32'h80);

        // Reset while restart is high: it must drop without waiting for a clock.
        reset = 1'b1;
        #1;
        push("midrst_rs", 32'd0);
        pop_check({31'd0, restart});
        push("midrst_ptf", 32'd0);
        pop_check({31'd0, predict_taken_f});
        @(posedge clk);
        #1;
        reset           = 1'b0;
        pc_f            = 32'h40;
        branch_d        = 1'b0;
        taken_d         = 1'b0;
        branch_target_d = 32'h0;
        #2;
        check_now("post_midrst", 1'b0, 32'h44, 1'b0, 32'h4);

        // Mispredicted branch held in D for two stalled cycles; lookups of
        // 0x40 must keep missing until the one real update.
        step("t1",  32'h40,  1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 32'h44,  1'b0, 32'h80);
        step("t2",  32'h40,  1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 32'h44,  1'b0, 32'h80);
        step("t3",  32'h40,  1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h44,  1'b1, 32'h80);
        step("t4",  32'h80,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h84,  1'b0, 32'h4);
        step("t5",  32'h40,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80,  1'b0, 32'h84);
        step("t6",  32'h80,  1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h84,  1'b0, 32'h80);
        step("t7",  32'h40,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80,  1'b0, 32'h84);
        step("t8",  32'h80,  1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h84,  1'b0, 32'h80);
        step("t9",  32'h40,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80,  1'b0, 32'h84);
`ifdef BP_STATS_EN
        push("stat_br", 32'd3);  pop_check(stat_branches);
        push("stat_mp", 32'd1);  pop_check(stat_mispredicts);
`endif
        // 0x40 was predicted taken but turns out to be a non-branch in D:
        // restart to 0x44 and the entry is dropped. 0x440 shares index 0 but
        // has a different tag, so its own lookup misses.
        step("t10", 32'h440, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h444, 1'b1, 32'h44);
        step("t11", 32'h44,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h48,  1'b0, 32'h4);
        step("t12", 32'h40,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h44,  1'b0, 32'h48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
